ps2_matrix_decoder: RTL
=======================

PS2_MATRIX_DECODER -- requirements
Module: ps2_matrix_decoder

Interface
REQ-001 The block SHALL have parameter COLS, default 14, meaning the number of matrix columns (address values 0..COLS-1).
REQ-002 The block SHALL have parameter ROWS, default 4, meaning the number of rows per column (1..8).
REQ-003 The block SHALL have parameter KEYBITS_W, default 8, meaning the keybits width, with ROWS <= KEYBITS_W.
REQ-004 The block SHALL have parameter SHIFT_COL, default 1, and parameter SHIFT_BIT, default 5, which together give the column and keybits bit where Shift is reported.
REQ-005 The block SHALL have these ports, one per line:
  - clk  in  1  system clock; single clock domain.
  - reset  in  1  synchronous, active-high reset.
  - rxData  in  8  received PS/2 byte.
  - rxValid  in  1  one-cycle strobe; rxData is valid in that cycle.
  - rxError  in  1  receiver framing or parity error strobe.
  - address  in  4  column select.
  - keybits  out  KEYBITS_W  row state of the selected column.
  - softReset  out  1  one-cycle pulse on the Ctrl+Alt+Del make code.
  - keyEvent  out  1  one-cycle strobe when the matrix changes.
  - keyEventData  out  8  {make, 3'b0, col[3:0]}, valid with keyEvent.

Function
REQ-006 The block SHALL hold a matrix of COLS x ROWS bits, one bit per key, so that any number of keys can be held down at the same time.
REQ-007 keybits SHALL be combinational from address: bit (KEYBITS_W-ROWS+r) = matrix[address][r], OR'd with Shift at SHIFT_BIT when address == SHIFT_COL.
  - keybits SHALL be 0 when address >= COLS.
REQ-008 The prefix FSM SHALL have states IDLE, E0, F0, E0F0 and SKIP, and SHALL change state only in a cycle where rxValid is high.
REQ-009 FSM transitions:
  - IDLE: 0xE0 -> E0; 0xF0 -> F0; 0xE1 -> SKIP with skip count 7.
  - E0: 0xF0 -> E0F0.
  - Any other byte SHALL be decoded and return the FSM to IDLE.
REQ-010 In SKIP, each byte SHALL decrement the skip count; the FSM SHALL return to IDLE when the count reaches 0; the matrix SHALL not change.
REQ-011 Decoding SHALL set make = 1 when no F0 prefix is present (states IDLE, E0) and make = 0 otherwise (states F0, E0F0).
REQ-012 Modifier codes SHALL only set the corresponding modifier register to make, without an E0 prefix check, and SHALL produce no keyEvent:
  - 0x11 = Alt; 0x14 = Ctrl; 0x12 = ShiftL; 0x59 = ShiftR.
  - Shift = ShiftL | ShiftR.
REQ-013 E0 0x71 with make=1, Ctrl=1, Alt=1 and Shift=0 SHALL pulse softReset for exactly 1 cycle, one cycle after the rxValid cycle; the matrix SHALL not change.
REQ-014 All other codes SHALL be looked up with their E0 flag; on a hit (col < COLS, row < ROWS) the block SHALL write matrix[col][row] <= make.
  - If the bit actually changed, keyEvent SHALL pulse one cycle after the rxValid cycle.
  - Typematic repeats (make of a key already set) SHALL produce no keyEvent.
REQ-015 A lookup miss SHALL be ignored silently.
REQ-016 Bytes 0xAA, 0xFC, 0x00 or 0xFF, or rxError=1, SHALL clear the matrix and all modifiers and return the FSM to IDLE in the next cycle.
  - rxError SHALL win over a simultaneous rxValid.
REQ-017 A key whose make was seen SHALL be released only by its own break code, or by the event in REQ-016.

Reset
REQ-018 On reset the block SHALL clear the matrix, all modifiers, the skip count and the FSM (to IDLE), and SHALL drive softReset=0, keyEvent=0 and keyEventData=0.
REQ-019 Reset SHALL dominate rxValid and rxError in the same cycle; a prefix sequence interrupted by reset SHALL be discarded.

Structure
REQ-020 A shared package ps2_pkg SHALL hold the FSM state enum, the prefix and special byte constants, and the default keymap table.
REQ-021 The block SHALL use exactly one sub-module, ps2_keymap: combinational {e0, code} -> {hit, col[3:0], row[2:0]}.
  - Defaults include: 0x15 Q -> (2,2); 0x1C A -> (2,1); 0x29 Space -> (1,0); 0x66 Backspace -> (C,3); E0 0x75 Up -> (D,3); E0 0x6B Left -> (D,2).

Verification
REQ-022 Bytes 15, 1C -> keybits at address 2 = 0x40, then 0x60; two keyEvents with data 0x82 each; then F0 15 -> 0x20, keyEventData 0x02.
REQ-023 Bytes 15, 15, 15 -> exactly one keyEvent; keybits at address 2 = 0x40.
REQ-024 Bytes 12 -> keybits at address 1 = 0x20; then 59, F0 12 -> still 0x20; then F0 59 -> 0x00.
REQ-025 Bytes 14, 11, E0 71 -> softReset high for exactly 1 cycle; with 12 also held -> no pulse.
REQ-026 Bytes E1 14 77 E1 F0 14 F0 77, then E0 75 -> no change until E0 75, after which keybits at address 13 = 0x80.
REQ-027 Hold 15, 29; then byte AA -> all columns read 0; separately, reset asserted after E0 -> next byte 75 is decoded as non-E0 (miss, no change).

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 decoder types: prefix FSM states, special byte codes and the default key map.
// Key map is purely combinational; no backpressure anywhere in this decoder.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0,
    ST_SKIP
  } state_t;

  localparam logic [7:0] PFX_E0      = 8'hE0;
  localparam logic [7:0] PFX_F0      = 8'hF0;
  localparam logic [7:0] PFX_E1      = 8'hE1;
  localparam logic [7:0] BYTE_BAT_OK = 8'hAA;
  localparam logic [7:0] BYTE_BAT_NG = 8'hFC;
  localparam logic [7:0] BYTE_OVR_LO = 8'h00;
  localparam logic [7:0] BYTE_OVR_HI = 8'hFF;
  localparam logic [7:0] CODE_ALT    = 8'h11;
  localparam logic [7:0] CODE_CTRL   = 8'h14;
  localparam logic [7:0] CODE_SHIFTL = 8'h12;
  localparam logic [7:0] CODE_SHIFTR = 8'h59;
  localparam logic [7:0] CODE_DEL    = 8'h71;
  // Pause/Break sends E1 followed by seven bytes that carry no key state.
  localparam logic [2:0] SKIP_LEN    = 3'd7;

  typedef struct packed {
    logic       hit;
    logic [3:0] col;
    logic [2:0] row;
  } keymap_t;

  function automatic logic is_wipe_byte(input logic [7:0] b);
    return (b == BYTE_BAT_OK) || (b == BYTE_BAT_NG) ||
           (b == BYTE_OVR_LO) || (b == BYTE_OVR_HI);
  endfunction

  // Index is {e0, scancode}.
  function automatic keymap_t keymap_lookup(input logic e0, input logic [7:0] code);
    keymap_t m;
    m = '0;
    case ({e0, code})
      9'h015: m = '{1'b1, 4'd2,  3'd2};  // Q
      9'h01C: m = '{1'b1, 4'd2,  3'd1};  // A
      9'h029: m = '{1'b1, 4'd1,  3'd0};  // Space
      9'h066: m = '{1'b1, 4'd12, 3'd3};  // Backspace
      9'h016: m = '{1'b1, 4'd2,  3'd3};  // 1
      9'h01E: m = '{1'b1, 4'd3,  3'd3};  // 2
      9'h026: m = '{1'b1, 4'd4,  3'd3};  // 3
      9'h01D: m = '{1'b1, 4'd3,  3'd2};  // W
      9'h024: m = '{1'b1, 4'd4,  3'd2};  // E
      9'h01B: m = '{1'b1, 4'd3,  3'd1};  // S
      9'h023: m = '{1'b1, 4'd4,  3'd1};  // D
      9'h01A: m = '{1'b1, 4'd3,  3'd0};  // Z
      9'h022: m = '{1'b1, 4'd4,  3'd0};  // X
      9'h05A: m = '{1'b1, 4'd12, 3'd2};  // Enter
      9'h076: m = '{1'b1, 4'd0,  3'd3};  // Esc
      9'h00D: m = '{1'b1, 4'd0,  3'd2};  // Tab
      9'h175: m = '{1'b1, 4'd13, 3'd3};  // Up
      9'h16B: m = '{1'b1, 4'd13, 3'd2};  // Left
      9'h172: m = '{1'b1, 4'd13, 3'd1};  // Down
      9'h174: m = '{1'b1, 4'd13, 3'd0};  // Right
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Scancode to matrix position lookup, combinational (0 cycles); no flow control.
module ps2_keymap
  import ps2_pkg::*;
(
  input  logic       e0,
  input  logic [7:0] code,
  output keymap_t    map
);

  always_comb begin
    map = keymap_lookup(e0, code);
  end

endmodule

// File: rtl/ps2_matrix_decoder.sv
// PS/2 scancode stream to key matrix; events/softReset registered one cycle after rxValid.
// No backpressure: every rxValid byte is consumed in the cycle it is presented.
module ps2_matrix_decoder
  import ps2_pkg::*;
#(
  parameter int COLS      = 14,
  parameter int ROWS      = 4,
  parameter int KEYBITS_W = 8,
  parameter int SHIFT_COL = 1,
  parameter int SHIFT_BIT = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rxData,
  input  logic                 rxValid,
  input  logic                 rxError,
  input  logic [3:0]           address,
  output logic [KEYBITS_W-1:0] keybits,
  output logic                 softReset,
  output logic                 keyEvent,
  output logic [7:0]           keyEventData
);

  state_t                     state_q, state_d;
  logic [2:0]                 skip_q, skip_d;
  logic [COLS-1:0][ROWS-1:0]  matrix_q, matrix_d;
  logic                       alt_q, alt_d, ctrl_q, ctrl_d;
  logic                       shl_q, shl_d, shr_q, shr_d;
  logic                       soft_reset_q, soft_reset_d;
  logic                       key_event_q, key_event_d;
  logic [7:0]                 key_event_data_q, key_event_data_d;

  logic    is_e0, make, shift, wipe, decode;
  logic    sel_vld, sel_val;
  keymap_t map;

  assign is_e0 = (state_q == ST_E0) || (state_q == ST_E0F0);
  assign make  = (state_q == ST_IDLE) || (state_q == ST_E0);
  assign shift = shl_q | shr_q;
  assign wipe  = rxError | (rxValid & is_wipe_byte(rxData));

  ps2_keymap u_keymap (
    .e0   (is_e0),
    .code (rxData),
    .map  (map)
  );

  // Codes mapping outside the configured matrix are treated as misses.
  always_comb begin
    sel_vld = 1'b0;
    sel_val = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (map.hit && c == int'(map.col) && r == int'(map.row)) begin
          sel_vld = 1'b1;
          sel_val = matrix_q[c][r];
        end
      end
    end
  end

  always_comb begin
    keybits = '0;
    for (int c = 0; c < COLS; c++) begin
      if (c == int'(address)) begin
        for (int r = 0; r < ROWS; r++) begin
          keybits[KEYBITS_W-ROWS+r] = matrix_q[c][r];
        end
      end
    end
    if (int'(address) == SHIFT_COL) begin
      keybits[SHIFT_BIT] = keybits[SHIFT_BIT] | shift;
    end
  end

  always_comb begin
    state_d          = state_q;
    skip_d           = skip_q;
    matrix_d         = matrix_q;
    alt_d            = alt_q;
    ctrl_d           = ctrl_q;
    shl_d            = shl_q;
    shr_d            = shr_q;
    soft_reset_d     = 1'b0;
    key_event_d      = 1'b0;
    key_event_data_d = key_event_data_q;
    decode           = 1'b0;

    if (wipe) begin
      state_d  = ST_IDLE;
      skip_d   = '0;
      matrix_d = '0;
      alt_d    = 1'b0;
      ctrl_d   = 1'b0;
      shl_d    = 1'b0;
      shr_d    = 1'b0;
    end else if (rxValid) begin
      case (state_q)
        ST_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = ST_IDLE;
        end
        ST_IDLE: begin
          if (rxData == PFX_E0)      state_d = ST_E0;
          else if (rxData == PFX_F0) state_d = ST_F0;
          else if (rxData == PFX_E1) begin
            state_d = ST_SKIP;
            skip_d  = SKIP_LEN;
          end else decode = 1'b1;
        end
        ST_E0: begin
          if (rxData == PFX_F0) state_d = ST_E0F0;
          else                  decode  = 1'b1;
        end
        default: decode = 1'b1;
      endcase
    end

    if (decode) begin
      state_d = ST_IDLE;
      if (rxData == CODE_ALT)         alt_d  = make;
      else if (rxData == CODE_CTRL)   ctrl_d = make;
      else if (rxData == CODE_SHIFTL) shl_d  = make;
      else if (rxData == CODE_SHIFTR) shr_d  = make;
      else if (is_e0 && rxData == CODE_DEL && make && ctrl_q && alt_q && !shift) begin
        soft_reset_d = 1'b1;
      end else if (sel_vld && sel_val != make) begin
        key_event_d      = 1'b1;
        key_event_data_d = {make, 3'b000, map.col};
        for (int c = 0; c < COLS; c++) begin
          for (int r = 0; r < ROWS; r++) begin
            if (c == int'(map.col) && r == int'(map.row)) matrix_d[c][r] = make;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      skip_q           <= '0;
      matrix_q         <= '0;
      alt_q            <= 1'b0;
      ctrl_q           <= 1'b0;
      shl_q            <= 1'b0;
      shr_q            <= 1'b0;
      soft_reset_q     <= 1'b0;
      key_event_q      <= 1'b0;
      key_event_data_q <= '0;
    end else begin
      state_q          <= state_d;
      skip_q           <= skip_d;
      matrix_q         <= matrix_d;
      alt_q            <= alt_d;
      ctrl_q           <= ctrl_d;
      shl_q            <= shl_d;
      shr_q            <= shr_d;
      soft_reset_q     <= soft_reset_d;
      key_event_q      <= key_event_d;
      key_event_data_q <= key_event_data_d;
    end
  end

  assign softReset    = soft_reset_q;
  assign keyEvent     = key_event_q;
  assign keyEventData = key_event_data_q;

endmodule
